// File: rtl/ai_ram_port_arbiter_if.sv
// Bus bundle between the four requesters, the arbiter and the dual-port sector RAM.
interface ai_ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic              avs_read;
  logic              avs_write;
  logic [ADDR_W-1:0] avs_address;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  logic              dma_write;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_data;
  logic              dma_ready;

  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_grant;
  logic              rd0_valid;
  logic [DATA_W-1:0] rd0_data;

  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_grant;
  logic              rd1_valid;
  logic [DATA_W-1:0] rd1_data;

  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_a;
  logic              ram_wren_a;
  logic [DATA_W-1:0] ram_q_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic              ram_wren_b;
  logic [DATA_W-1:0] ram_q_b;

  // Arbiter side.
  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  dma_write, dma_addr, dma_data,
    output dma_ready,
    input  rd0_req, rd0_addr,
    output rd0_grant, rd0_valid, rd0_data,
    input  rd1_req, rd1_addr,
    output rd1_grant, rd1_valid, rd1_data,
    output ram_addr_a, ram_data_a, ram_wren_a,
    input  ram_q_a,
    output ram_addr_b, ram_data_b, ram_wren_b,
    input  ram_q_b
  );

  // Requester / RAM side.
  modport master (
    output avs_read, avs_write, avs_address, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    output dma_write, dma_addr, dma_data,
    input  dma_ready,
    output rd0_req, rd0_addr,
    input  rd0_grant, rd0_valid, rd0_data,
    output rd1_req, rd1_addr,
    input  rd1_grant, rd1_valid, rd1_data,
    input  ram_addr_a, ram_data_a, ram_wren_a,
    output ram_q_a,
    input  ram_addr_b, ram_data_b, ram_wren_b,
    output ram_q_b
  );
endinterface

// File: rtl/ai_ram_port_arbiter.sv
// Two-port arbiter for one dual-port AI sector RAM (1-cycle registered read).
// Port A: Avalon host vs reader 0 with a starvation guard on reader 0.
// Port B: DMA writer vs reader 1, round-robin, with host/DMA write-collision stall.
module ai_ram_port_arbiter #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ai_ram_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {A_HOST = 1'b0, A_RD0 = 1'b1} a_state_e;

  a_state_e          a_state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              b_pref_dma_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic              avs_rvalid_q, rd0_valid_q, rd1_valid_q;
  logic [DATA_W-1:0] avs_rdata_q, rd0_rdata_q, rd1_rdata_q;

  logic              host_req, host_wr, rd0_req, dma_req, rd1_req;
  logic              host_gnt, rd0_gnt, dma_win, dma_gnt, rd1_gnt, wr_collide;
  logic [ADDR_W-1:0] addr_a_c, addr_b_c;
  logic [DATA_W-1:0] data_a_c, data_b_c;
  logic              wren_a_c, wren_b_c;
  logic [DATA_W-1:0] avs_rdata_c, rd0_rdata_c, rd1_rdata_c;

  // Winner selection and RAM strobes; every request is masked while in reset.
  always_comb begin
    host_req   = rst & (bus.avs_read | bus.avs_write);
    host_wr    = rst & bus.avs_write;  // read+write together is handled as a write
    rd0_req    = rst & bus.rd0_req;
    dma_req    = rst & bus.dma_write;
    rd1_req    = rst & bus.rd1_req;

    host_gnt   = host_req & ~(rd0_req & (a_state_q == A_RD0));
    rd0_gnt    = rd0_req & ~(host_req & (a_state_q == A_HOST));

    dma_win    = dma_req & (b_pref_dma_q | ~rd1_req);
    wr_collide = host_gnt & host_wr & dma_win & (bus.avs_address == bus.dma_addr);
    dma_gnt    = dma_win & ~wr_collide;
    rd1_gnt    = rd1_req & ~dma_gnt;

    addr_a_c   = addr_a_q;
    if (host_gnt) begin
      addr_a_c = bus.avs_address;
    end else if (rd0_gnt) begin
      addr_a_c = bus.rd0_addr;
    end
    wren_a_c   = host_gnt & host_wr;
    data_a_c   = wren_a_c ? bus.avs_writedata : '0;

    addr_b_c   = addr_b_q;
    if (dma_gnt) begin
      addr_b_c = bus.dma_addr;
    end else if (rd1_gnt) begin
      addr_b_c = bus.rd1_addr;
    end
    wren_b_c   = dma_gnt;
    data_b_c   = dma_gnt ? bus.dma_data : '0;

    avs_rdata_c = avs_rvalid_q ? bus.ram_q_a : avs_rdata_q;
    rd0_rdata_c = rd0_valid_q  ? bus.ram_q_a : rd0_rdata_q;
    rd1_rdata_c = rd1_valid_q  ? bus.ram_q_b : rd1_rdata_q;
  end

  // Port A guard FSM, port B round-robin, address hold and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_state_q    <= A_HOST;
      wait_cnt_q   <= '0;
      b_pref_dma_q <= 1'b1;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      avs_rvalid_q <= 1'b0;
      rd0_valid_q  <= 1'b0;
      rd1_valid_q  <= 1'b0;
      avs_rdata_q  <= '0;
      rd0_rdata_q  <= '0;
      rd1_rdata_q  <= '0;
    end else begin
      addr_a_q     <= addr_a_c;
      addr_b_q     <= addr_b_c;
      avs_rvalid_q <= host_gnt & ~host_wr;
      rd0_valid_q  <= rd0_gnt;
      rd1_valid_q  <= rd1_gnt;
      avs_rdata_q  <= avs_rdata_c;
      rd0_rdata_q  <= rd0_rdata_c;
      rd1_rdata_q  <= rd1_rdata_c;

      case (a_state_q)
        A_HOST: begin
          if (rd0_gnt) begin
            wait_cnt_q <= '0;
          end else if (rd0_req) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (wait_cnt_q + CNT_W'(1) == CNT_W'(MAX_WAIT)) begin
              a_state_q <= A_RD0;
            end
          end
        end
        A_RD0: begin
          if (rd0_gnt) begin
            wait_cnt_q <= '0;
            a_state_q  <= A_HOST;
          end
        end
        default: a_state_q <= A_HOST;
      endcase

      // A collision-forced outcome leaves the round-robin pointer untouched.
      if (!wr_collide) begin
        if (dma_gnt) begin
          b_pref_dma_q <= 1'b0;
        end else if (rd1_gnt) begin
          b_pref_dma_q <= 1'b1;
        end
      end
    end
  end

  assign bus.avs_waitrequest   = host_req & ~host_gnt;
  assign bus.avs_readdatavalid = avs_rvalid_q;
  assign bus.avs_readdata      = avs_rdata_c;
  assign bus.dma_ready         = dma_gnt;
  assign bus.rd0_grant         = rd0_gnt;
  assign bus.rd0_valid         = rd0_valid_q;
  assign bus.rd0_data          = rd0_rdata_c;
  assign bus.rd1_grant         = rd1_gnt;
  assign bus.rd1_valid         = rd1_valid_q;
  assign bus.rd1_data          = rd1_rdata_c;
  assign bus.ram_addr_a        = addr_a_c;
  assign bus.ram_data_a        = data_a_c;
  assign bus.ram_wren_a        = wren_a_c;
  assign bus.ram_addr_b        = addr_b_c;
  assign bus.ram_data_b        = data_b_c;
  assign bus.ram_wren_b        = wren_b_c;
endmodule

// File: tb/tb_ai_ram_port_arbiter.sv
// Bench for ai_ram_port_arbiter: vector table plus arbitration / collision sequences
// against a small behavioural dual-port RAM with 1-cycle registered read.
module tb_ai_ram_port_arbiter;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned N_VEC    = 20;

  typedef struct packed {
    logic        rn, rd, wr;
    logic [12:0] aa;
    logic [7:0]  ad;
    logic        dw;
    logic [12:0] da;
    logic [7:0]  dd;
    logic        r0;
    logic [12:0] r0a;
    logic        r1;
    logic [12:0] r1a;
    logic [8:0]  ef;   // {wait, dma_ready, g0, g1, wren_a, wren_b, avs_valid, rd0_valid, rd1_valid}
    logic [12:0] ea, eb;
    logic [7:0]  erd, ed0, ed1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  ai_ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ai_ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural sector RAM; a few words are preloaded while reset is held.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    bus.ram_q_a <= mem[bus.ram_addr_a];
    bus.ram_q_b <= mem[bus.ram_addr_b];
    if (!rst) begin
      mem[13'h010] <= 8'hA5;
      mem[13'h020] <= 8'h3C;
      mem[13'h030] <= 8'hC3;
      mem[13'h040] <= 8'h5A;
    end else begin
      if (bus.ram_wren_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_wren_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
    end
  end

  function automatic vec_t mk(int rn, int rd, int wr, int aa, int ad, int dw, int da, int dd,
                              int r0, int r0a, int r1, int r1a, int ef, int ea, int eb,
                              int erd, int ed0, int ed1);
    vec_t v;
    v.rn = 1'(rn);   v.rd = 1'(rd);   v.wr = 1'(wr);
    v.aa = 13'(aa);  v.ad = 8'(ad);
    v.dw = 1'(dw);   v.da = 13'(da);  v.dd = 8'(dd);
    v.r0 = 1'(r0);   v.r0a = 13'(r0a);
    v.r1 = 1'(r1);   v.r1a = 13'(r1a);
    v.ef = 9'(ef);   v.ea = 13'(ea);  v.eb = 13'(eb);
    v.erd = 8'(erd); v.ed0 = 8'(ed0); v.ed1 = 8'(ed1);
    return v;
  endfunction

  // Apply one cycle of inputs just after the rising edge, then settle to the falling edge.
  task automatic drive(int rn, int rd, int wr, int aa, int ad, int dw, int da, int dd,
                       int r0, int r0a, int r1, int r1a);
    @(posedge clk);
    #1;
    rst               = 1'(rn);
    bus.avs_read      = 1'(rd);
    bus.avs_write     = 1'(wr);
    bus.avs_address   = 13'(aa);
    bus.avs_writedata = 8'(ad);
    bus.dma_write     = 1'(dw);
    bus.dma_addr      = 13'(da);
    bus.dma_data      = 8'(dd);
    bus.rd0_req       = 1'(r0);
    bus.rd0_addr      = 13'(r0a);
    bus.rd1_req       = 1'(r1);
    bus.rd1_addr      = 13'(r1a);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t       tbl [N_VEC];
  vec_t       v;
  logic [8:0] flags;
  logic       e_a, e_b, e_c;

  initial begin
    rst = 1'b0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_address = '0; bus.avs_writedata = '0;
    bus.dma_write = 1'b0; bus.dma_addr = '0; bus.dma_data = '0;
    bus.rd0_req = 1'b0; bus.rd0_addr = '0; bus.rd1_req = 1'b0; bus.rd1_addr = '0;

    //           rn rd wr aa     ad    dw da     dd    r0 r0a    r1 r1a    flags         ea     eb     rd    d0    d1
    tbl[0]  = mk(0, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 0,     0,     0,    0,    0);
    tbl[1]  = mk(1, 1, 0, 'h10,  0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 'h10,  0,     0,    0,    0);
    tbl[2]  = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000100, 'h10,  0,     'hA5, 0,    0);
    tbl[3]  = mk(1, 0, 0, 0,     0,    0, 0,     0,    1, 'h20,  1, 'h30,  'b001100000, 'h20,  'h30,  'hA5, 0,    0);
    tbl[4]  = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000011, 'h20,  'h30,  'hA5, 'h3C, 'hC3);
    tbl[5]  = mk(1, 0, 1, 'h100, 'h11, 1, 'h100, 'h22, 0, 0,     0, 0,     'b000010000, 'h100, 'h30,  'hA5, 'h3C, 'hC3);
    tbl[6]  = mk(1, 0, 0, 0,     0,    1, 'h100, 'h22, 0, 0,     0, 0,     'b010001000, 'h100, 'h100, 'hA5, 'h3C, 'hC3);
    tbl[7]  = mk(1, 1, 0, 'h100, 0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 'h100, 'h100, 'hA5, 'h3C, 'hC3);
    tbl[8]  = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000100, 'h100, 'h100, 'h22, 'h3C, 'hC3);
    tbl[9]  = mk(1, 0, 1, 'h50,  'h77, 0, 0,     0,    1, 'h10,  0, 0,     'b000010000, 'h50,  'h100, 'h22, 'h3C, 'hC3);
    tbl[10] = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 'h50,  'h100, 'h22, 'h3C, 'hC3);
    tbl[11] = mk(1, 0, 0, 0,     0,    0, 0,     0,    1, 'h10,  0, 0,     'b001000000, 'h10,  'h100, 'h22, 'h3C, 'hC3);
    tbl[12] = mk(1, 1, 0, 'h40,  0,    1, 'h40,  'h99, 0, 0,     0, 0,     'b010001010, 'h40,  'h40,  'h22, 'hA5, 'hC3);
    tbl[13] = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000100, 'h40,  'h40,  'h5A, 'hA5, 'hC3);
    tbl[14] = mk(1, 1, 0, 'h40,  0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 'h40,  'h40,  'h5A, 'hA5, 'hC3);
    tbl[15] = mk(1, 1, 0, 'h30,  0,    0, 0,     0,    1, 'h10,  0, 0,     'b000000100, 'h30,  'h40,  'h99, 'hA5, 'hC3);
    tbl[16] = mk(0, 1, 0, 'h20,  0,    0, 0,     0,    0, 0,     0, 0,     'b000000100, 'h30,  'h40,  'hC3, 'hA5, 'hC3);
    tbl[17] = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 0,     0,     0,    0,    0);
    tbl[18] = mk(1, 1, 0, 'h20,  0,    0, 0,     0,    0, 0,     0, 0,     'b000000000, 'h20,  0,     0,    0,    0);
    tbl[19] = mk(1, 0, 0, 0,     0,    0, 0,     0,    0, 0,     0, 0,     'b000000100, 'h20,  0,     'h3C, 0,    0);

    // Hold reset for two edges so every register starts known.
    repeat (2) @(posedge clk);

    for (int i = 0; i < int'(N_VEC); i++) begin
      v = tbl[i];
      drive(int'(v.rn), int'(v.rd), int'(v.wr), int'(v.aa), int'(v.ad), int'(v.dw), int'(v.da),
            int'(v.dd), int'(v.r0), int'(v.r0a), int'(v.r1), int'(v.r1a));
      flags = {bus.avs_waitrequest, bus.dma_ready, bus.rd0_grant, bus.rd1_grant, bus.ram_wren_a,
               bus.ram_wren_b, bus.avs_readdatavalid, bus.rd0_valid, bus.rd1_valid};
      check($sformatf("vec%0d", i),
            64'({flags, bus.ram_addr_a, bus.ram_addr_b, bus.avs_readdata, bus.rd0_data, bus.rd1_data}),
            64'({v.ef, v.ea, v.eb, v.erd, v.ed0, v.ed1}));
    end

    // Host vs reader 0 continuously: reader 0 forced through every 5th cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 'h10, 0, 0, 0, 0, 1, 'h20, 0, 0);
      e_a = (i % 5 == 4);
      e_b = (i > 0) && ((i - 1) % 5 == 4);
      e_c = (i > 0) && ((i - 1) % 5 != 4);
      check($sformatf("starve%0d", i),
            64'({bus.rd0_grant, bus.avs_waitrequest, bus.rd0_valid, bus.avs_readdatavalid, bus.ram_addr_a}),
            64'({e_a, e_a, e_b, e_c, (e_a ? 13'h20 : 13'h10)}));
    end

    // DMA vs reader 1 continuously: strict alternation starting with DMA.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 1, 'h300 + i, i, 0, 0, 1, 'h30);
      e_a = (i % 2 == 0);
      e_b = (i > 0) && ((i - 1) % 2 == 1);
      check($sformatf("rr%0d", i),
            64'({bus.dma_ready, bus.rd1_grant, bus.ram_wren_b, bus.rd1_valid, bus.ram_addr_b}),
            64'({e_a, ~e_a, e_a, e_b, (e_a ? 13'('h300 + i) : 13'h30)}));
    end

    // Collision without reader 1: port B idles and the pointer stays on DMA.
    drive(1, 0, 1, 'h200, 'h44, 1, 'h200, 'h55, 0, 0, 0, 0);
    check("coll_idle", 64'({bus.avs_waitrequest, bus.dma_ready, bus.rd1_grant, bus.ram_wren_a, bus.ram_wren_b}),
          64'(5'b00010));
    drive(1, 0, 0, 0, 0, 1, 'h200, 'h55, 0, 0, 1, 'h30);
    check("coll_rr", 64'({bus.avs_waitrequest, bus.dma_ready, bus.rd1_grant, bus.ram_wren_a, bus.ram_wren_b}),
          64'(5'b01001));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h30);
    check("rd1_only", 64'({bus.avs_waitrequest, bus.dma_ready, bus.rd1_grant, bus.ram_wren_a, bus.ram_wren_b}),
          64'(5'b00100));
    // Collision with reader 1 requesting: port B goes to reader 1.
    drive(1, 0, 1, 'h210, 'h01, 1, 'h210, 'h66, 0, 0, 1, 'h30);
    check("coll_rd1", 64'({bus.avs_waitrequest, bus.dma_ready, bus.rd1_grant, bus.ram_wren_a, bus.ram_wren_b,
                           bus.ram_addr_b}),
          64'({5'b00110, 13'h30}));

    // Host writes only: never a read valid, port B never writes.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 'h400 + i, i + 1, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("hwr%0d", i),
            64'({bus.avs_readdatavalid, bus.ram_wren_b, bus.avs_waitrequest, bus.ram_wren_a, bus.ram_data_a}),
            64'({4'b0001, 8'(i + 1)}));
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hwr_idle", 64'({bus.avs_readdatavalid, bus.ram_wren_a, bus.ram_wren_b, bus.ram_data_a, bus.ram_data_b,
                           bus.ram_addr_a}),
          64'({3'b000, 8'h00, 8'h00, 13'h405}));

    // Final RAM contents after the collisions.
    @(negedge clk);
    check("mem_100", 64'(mem[13'h100]), 64'(8'h22));
    check("mem_200", 64'(mem[13'h200]), 64'(8'h55));
    check("mem_210", 64'(mem[13'h210]), 64'(8'h01));
    check("mem_405", 64'(mem[13'h405]), 64'(8'h06));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ai_ram_port_arbiter.md
Name: ai_ram_port_arbiter

Overview:
- Shares the two ports of one dual-port AI sector RAM (1-cycle registered read) between four requesters.
- Port A serves the Avalon host and inference reader 0; port B serves the DMA writer and inference reader 1.
- Adds per-port grant FSMs, a starvation guard, same-address write-collision stall, and read-valid tracking, so the sector itself needs no muxing logic.

Parameters:
- ADDR_W, 13, RAM word address width.
- DATA_W, 8, data width.
- MAX_WAIT, 4, consecutive denied cycles after which a requester gets forced priority (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write.
- avs_address  in  ADDR_W  Avalon address.
- avs_writedata  in  DATA_W  Avalon write data.
- avs_waitrequest  out  1  Avalon stall.
- avs_readdata  out  DATA_W  Avalon read data.
- avs_readdatavalid  out  1  Avalon read data valid.
- dma_write  in  1  DMA write request.
- dma_addr  in  ADDR_W  DMA address.
- dma_data  in  DATA_W  DMA data.
- dma_ready  out  1  DMA write accepted this cycle.
- rd0_req  in  1  reader 0 request.
- rd0_addr  in  ADDR_W  reader 0 address.
- rd0_grant  out  1  reader 0 request accepted.
- rd0_valid  out  1  reader 0 data valid.
- rd0_data  out  DATA_W  reader 0 data.
- rd1_req  in  1  reader 1 request.
- rd1_addr  in  ADDR_W  reader 1 address.
- rd1_grant  out  1  reader 1 request accepted.
- rd1_valid  out  1  reader 1 data valid.
- rd1_data  out  DATA_W  reader 1 data.
- ram_addr_a  out  ADDR_W  RAM port A address.
- ram_data_a  out  DATA_W  RAM port A write data.
- ram_wren_a  out  1  RAM port A write enable.
- ram_q_a  in  DATA_W  RAM port A read data.
- ram_addr_b  out  ADDR_W  RAM port B address.
- ram_data_b  out  DATA_W  RAM port B write data.
- ram_wren_b  out  1  RAM port B write enable.
- ram_q_b  in  DATA_W  RAM port B read data.

Behaviour:
- Grants are combinational from requests and registered state. RAM strobes are driven combinationally from the winner in the same cycle.
- Idle port: address holds the last granted address; wren=0; data=0.
- Port A FSM states: A_HOST (host preferred) and A_RD0 (reader 0 preferred).
  - In A_HOST: host wins a conflict, and reader 0's wait counter increments per denied cycle.
  - When the counter reaches MAX_WAIT, go to A_RD0.
  - In A_RD0: reader 0 wins one conflict; the counter clears and the FSM returns to A_HOST.
  - The counter also clears on any reader 0 grant.
- Port B FSM: plain round-robin between DMA and reader 1; the last winner gets lower priority on the next conflict.
- Host stall: avs_waitrequest = (avs_read|avs_write) & ~host_granted.
- DMA accept: dma_ready = dma_write & dma_granted.
- Read latency: exactly 1 cycle.
  - avs_readdatavalid, rd0_valid and rd1_valid are registered copies of the respective read grants.
  - Data outputs take ram_q_a / ram_q_b in that cycle and hold their value when not valid.
  - Host write grants never raise avs_readdatavalid.
- Write collision: host write and DMA granted in the same cycle to the same address → host write wins, and the DMA is not granted (dma_ready=0).
  - Port B then goes to reader 1 if it is requesting, otherwise it idles.
  - This does not update round-robin state.
- Host read + DMA write to the same address in the same cycle: both proceed; the host reads the old data. This is documented, not blocked.
- avs_read & avs_write together is illegal; treat it as a write.
- Reset (rst=0, sampled on clk):
  - All outputs are 0 and addresses are 0.
  - FSMs go to A_HOST; port B prefers DMA; wait counter is 0.
  - In-flight valids are dropped, so no valid appears in the cycle after reset even if a grant was issued the cycle before.

Test Plan:
- Host read at 0x0010 with RAM holding 0xA5 and no other traffic → waitrequest=0, RAM addr_a=0x0010; next cycle avs_readdatavalid=1, avs_readdata=0xA5.
- Host and reader 0 request continuously with MAX_WAIT=4 → host granted 4 cycles, reader 0 granted on cycle 5, pattern repeats; rd0_valid follows each rd0_grant by 1 cycle.
- DMA and reader 1 both request continuously → grants alternate DMA, RD1, DMA, …; dma_ready high on alternate cycles.
- Host write 0x0100←0x11 with DMA write 0x0100←0x22 in the same cycle → ram_wren_a=1, dma_ready=0; DMA granted next cycle, final RAM content 0x22.
- rst driven low while a host read is granted → next cycle avs_readdatavalid=0, all grants 0; after release the first host read completes normally.
- Host write only → avs_readdatavalid never asserted; ram_wren_b stays 0 throughout.
